// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- data-memory controller arbitrating a core port and a debug
// port onto a single 32-bit word-wide memory with combinational reads.
// Sub-word stores are performed as read-modify-write. Misaligned accesses
// complete with an error and never touch memory.
//
// Optional feature: define DMEM_RR_ARB_EN for round-robin arbitration
// between core and debug. Without it, the core has fixed priority.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   c_req/c_we/c_size/c_uns     core request, store, size, unsigned load
//   c_addr/c_wdata              core address and store data
//   c_rdata/c_ack/c_err/stall   core load data, completion, misaligned, stall
//   d_req/d_we/d_addr/d_wdata   debug request (word only)
//   d_rdata/d_ack/d_err         debug load data, completion, misaligned
//   mem_rd/mem_wr/mem_cs_n      memory strobes (select active low)
//   mem_addr/mem_wdata          memory word address and write data
//   mem_rdata                   memory read data (combinational)
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [1:0]  c_size,
  input  logic        c_uns,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  output logic        c_err,
  output logic        stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_cs_n,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  logic [2:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rword_q, rword_d;
  logic        err_q, err_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        grant_dbg;
  logic        sel_we, sel_uns, sel_mis;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic        res_en, res_own;
  logic [31:0] res_data;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_ext = {{24{b[7] & ~uns}}, b};
      2'b01:   load_ext = {{16{h[15] & ~uns}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] lo, input logic [1:0] sz);
    logic [31:0] m;
    m = w;
    if (sz == 2'b00) begin
      case (lo)
        2'd0:    m[7:0]   = d[7:0];
        2'd1:    m[15:8]  = d[7:0];
        2'd2:    m[23:16] = d[7:0];
        default: m[31:24] = d[7:0];
      endcase
    end else if (lo[1]) begin
      m[31:16] = d[15:0];
    end else begin
      m[15:0] = d[15:0];
    end
    merge = m;
  endfunction

`ifdef DMEM_RR_ARB_EN
  // rr_q names the port that wins the next contested grant.
  logic rr_q, rr_d;
  assign grant_dbg = d_req & (~c_req | (rr_q == OWN_DBG));
`else
  assign grant_dbg = d_req & ~c_req;
`endif

  // Debug accesses are always unsigned-irrelevant full words.
  assign sel_we    = grant_dbg ? d_we    : c_we;
  assign sel_size  = grant_dbg ? 2'b10   : c_size;
  assign sel_uns   = grant_dbg ? 1'b0    : c_uns;
  assign sel_addr  = grant_dbg ? d_addr  : c_addr;
  assign sel_wdata = grant_dbg ? d_wdata : c_wdata;
  assign sel_mis   = ((sel_size == 2'b01) & sel_addr[0]) |
                     (sel_size[1] & (sel_addr[1:0] != 2'b00));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rword_d   = rword_q;
    err_d     = err_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    res_en    = 1'b0;
    res_own   = owner_q;
    res_data  = '0;
`ifdef DMEM_RR_ARB_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (c_req | d_req) begin
          owner_d = grant_dbg;
          we_d    = sel_we;
          size_d  = sel_size;
          uns_d   = sel_uns;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = sel_mis;
`ifdef DMEM_RR_ARB_EN
          rr_d    = ~grant_dbg;
`endif
          if (sel_mis) begin
            res_en  = 1'b1;
            res_own = grant_dbg;
            state_d = S_DONE;
          end else if (!sel_we) begin
            state_d = S_RD;
          end else if (sel_size[1]) begin
            state_d = S_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        rword_d  = mem_rdata;
        res_en   = 1'b1;
        res_data = load_ext(mem_rdata, addr_q[1:0], size_q, uns_q);
        state_d  = S_DONE;
      end
      S_WR: begin
        res_en  = 1'b1;
        state_d = S_DONE;
      end
      S_RMW_RD: begin
        rword_d = mem_rdata;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        res_en  = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Result register of the owning port is loaded on entry to DONE, so it
    // stays stable until that port's next completion.
    if (res_en) begin
      if (res_own == OWN_DBG) d_rdata_d = res_data;
      else                    c_rdata_d = res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_CORE;
      we_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rword_q   <= '0;
      err_q     <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef DMEM_RR_ARB_EN
      rr_q      <= OWN_CORE;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rword_q   <= rword_d;
      err_q     <= err_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef DMEM_RR_ARB_EN
      rr_q      <= rr_d;
`endif
    end
  end

  logic active, is_rd, is_wr, done;
  assign is_rd  = (state_q == S_RD) | (state_q == S_RMW_RD);
  assign is_wr  = (state_q == S_WR) | (state_q == S_RMW_WR);
  assign active = is_rd | is_wr;
  assign done   = (state_q == S_DONE);

  assign mem_rd    = is_rd;
  assign mem_wr    = is_wr;
  assign mem_cs_n  = ~active;
  assign mem_addr  = active ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata = (state_q == S_WR)     ? wdata_q :
                     (state_q == S_RMW_WR) ? merge(rword_q, wdata_q, addr_q[1:0], size_q) :
                     '0;

  assign c_ack   = done & (owner_q == OWN_CORE);
  assign d_ack   = done & (owner_q == OWN_DBG);
  assign c_err   = c_ack & err_q;
  assign d_err   = d_ack & err_q;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;
  assign stall   = c_req & ~c_ack;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl -- scoreboard bench for dmem_ctrl with a behavioural
// word-wide memory. Stimulus tasks push expected responses (data, error,
// ack cycle); a negedge monitor pops and compares on every ack.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_uns;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_ack, c_err, stall;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ack, d_err;
  logic        mem_rd, mem_wr, mem_cs_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_uns(c_uns),
    .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack), .c_err(c_err), .stall(stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_cs_n(mem_cs_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory with a bench-side preload port.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (!mem_cs_n && mem_wr) mem[mem_addr[11:2]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[11:2]];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t exp_c[$];
  exp_t exp_d[$];
  int   ack_log[$];
  exp_t ec, ed;
  int   errors = 0;
  int   checks = 0;
  logic cs_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (c_ack === 1'b1) begin
        ack_log.push_back(0);
        if (exp_c.size() == 0) begin
          checks++; errors++;
          $display("FAIL core_unexpected_ack: got ack at cycle %0d expected none", cyc);
        end else begin
          ec = exp_c.pop_front();
          chk("core_rdata", c_rdata, ec.rdata);
          chk("core_err", {31'b0, c_err}, {31'b0, ec.err});
          chk("core_ack_cycle", cyc, ec.cyc);
        end
      end
      if (d_ack === 1'b1) begin
        ack_log.push_back(1);
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL dbg_unexpected_ack: got ack at cycle %0d expected none", cyc);
        end else begin
          ed = exp_d.pop_front();
          chk("dbg_rdata", d_rdata, ed.rdata);
          chk("dbg_err", {31'b0, d_err}, {31'b0, ed.err});
          chk("dbg_ack_cycle", cyc, ed.cyc);
        end
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = a[11:2]; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic core_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int unsigned lat);
    exp_t e;
    int unsigned n;
    @(posedge clk); #1;
    c_we = we; c_size = sz; c_uns = uns; c_addr = a; c_wdata = wd; c_req = 1'b1;
    e.rdata = er; e.err = ee; e.cyc = cyc + lat;
    exp_c.push_back(e);
    cs_seen = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_cs_n === 1'b0) cs_seen = 1'b1;
      chk("core_stall", {31'b0, stall}, {31'b0, ~c_ack});
    end while (c_ack !== 1'b1 && n < 20);
    if (c_ack !== 1'b1) begin
      checks++; errors++;
      $display("FAIL core_timeout: got no ack after %0d cycles expected ack", n);
      exp_c.delete();
    end
    @(posedge clk); #1;
    c_req = 1'b0;
    @(negedge clk);
    chk("core_rdata_hold", c_rdata, er);
  endtask

  task automatic dbg_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int unsigned lat);
    exp_t e;
    int unsigned n;
    @(posedge clk); #1;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    e.rdata = er; e.err = ee; e.cyc = cyc + lat;
    exp_d.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (d_ack !== 1'b1 && n < 20);
    if (d_ack !== 1'b1) begin
      checks++; errors++;
      $display("FAIL dbg_timeout: got no ack after %0d cycles expected ack", n);
      exp_d.delete();
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  int unsigned n0;
  int          exp_seq [3];

  initial begin
    rst = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_size = 2'b00; c_uns = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_c_ack", {31'b0, c_ack}, 32'd0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("rst_c_err", {31'b0, c_err}, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_cs_n", {31'b0, mem_cs_n}, 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    #1 rst = 1'b0;

    preload(32'h0, 32'h0);
    // sw / lw
    core_op(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("mem_sw_100", mem[32'h100 >> 2], 32'hDEADBEEF);
    core_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    // byte RMW and loads
    preload(32'h200, 32'h11223344);
    core_op(1'b1, 2'b00, 1'b0, 32'h202, 32'h000000AA, 32'h0, 1'b0, 3);
    chk("mem_sb_202", mem[32'h200 >> 2], 32'h11AA3344);
    core_op(1'b0, 2'b00, 1'b0, 32'h202, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
    core_op(1'b0, 2'b00, 1'b1, 32'h202, 32'h0, 32'h000000AA, 1'b0, 2);
    // misaligned half: error, no memory select
    core_op(1'b0, 2'b01, 1'b0, 32'h201, 32'h0, 32'h0, 1'b1, 1);
    chk("mis_no_cs", {31'b0, cs_seen}, 32'd0);
    // half RMW into upper lanes
    core_op(1'b1, 2'b01, 1'b0, 32'h202, 32'h00008001, 32'h0, 1'b0, 3);
    chk("mem_sh_202", mem[32'h200 >> 2], 32'h80013344);
    core_op(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'hFFFF8001, 1'b0, 2);
    core_op(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h00008001, 1'b0, 2);
    core_op(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 32'h00000044, 1'b0, 2);
    core_op(1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 32'h00000033, 1'b0, 2);
    core_op(1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 32'h00003344, 1'b0, 2);
    // byte store uses only wdata[7:0]
    core_op(1'b1, 2'b00, 1'b0, 32'h203, 32'hFFFFFF99, 32'h0, 1'b0, 3);
    chk("mem_sb_203", mem[32'h200 >> 2], 32'h99013344);
    core_op(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'hFFFFFF99, 1'b0, 2);
    // misaligned word, size 11 as word
    core_op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1);
    core_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    // debug port
    dbg_op(1'b1, 32'h400, 32'h12345678, 32'h0, 1'b0, 2);
    chk("mem_dbg_sw", mem[32'h400 >> 2], 32'h12345678);
    dbg_op(1'b0, 32'h400, 32'h0, 32'h12345678, 1'b0, 2);
    dbg_op(1'b0, 32'h402, 32'h0, 32'h0, 1'b1, 1);

    // Both ports requesting continuously.
    ack_log.delete();
    @(posedge clk); #1;
    c_we = 1'b0; c_size = 2'b10; c_uns = 1'b0; c_addr = 32'h100; c_req = 1'b1;
    d_we = 1'b0; d_addr = 32'h400; d_req = 1'b1;
    n0 = cyc;
    ec.rdata = 32'hDEADBEEF; ec.err = 1'b0;
    ed.rdata = 32'h12345678; ed.err = 1'b0;
`ifdef DMEM_RR_ARB_EN
    ec.cyc = n0 + 2; exp_c.push_back(ec);
    ed.cyc = n0 + 5; exp_d.push_back(ed);
    ec.cyc = n0 + 8; exp_c.push_back(ec);
    exp_seq = '{0, 1, 0};
`else
    ec.cyc = n0 + 2; exp_c.push_back(ec);
    ec.cyc = n0 + 5; exp_c.push_back(ec);
    ec.cyc = n0 + 8; exp_c.push_back(ec);
    exp_seq = '{0, 0, 0};
`endif
    repeat (9) @(posedge clk);
    #1;
    c_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("arb_ack_count", ack_log.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < ack_log.size()) chk("arb_ack_order", ack_log[i], exp_seq[i]);
    end
    chk("arb_core_queue_empty", exp_c.size(), 32'd0);

    // Reset during RMW_RD of a half store.
    preload(32'h300, 32'h55667788);
    @(posedge clk); #1;
    c_we = 1'b1; c_size = 2'b01; c_uns = 1'b0; c_addr = 32'h300; c_wdata = 32'h0000BEEF;
    c_req = 1'b1;
    @(posedge clk); #1;
    chk("rmw_rd_active", {30'b0, mem_rd, mem_cs_n}, 32'd2);
    rst = 1'b1; c_req = 1'b0;
    @(posedge clk); #1;
    chk("abort_c_ack", {31'b0, c_ack}, 32'd0);
    chk("abort_d_ack", {31'b0, d_ack}, 32'd0);
    chk("abort_c_err", {31'b0, c_err}, 32'd0);
    chk("abort_d_err", {31'b0, d_err}, 32'd0);
    chk("abort_c_rdata", c_rdata, 32'd0);
    chk("abort_d_rdata", d_rdata, 32'd0);
    chk("abort_strobes", {29'b0, mem_rd, mem_wr, mem_cs_n}, 32'd1);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_mem_300", mem[32'h300 >> 2], 32'h55667788);
    core_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h55667788, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
